fys_mux_driver: RTL and testbench

//   Parametrised multi-digit, time-multiplexed 7-segment display driver. Shows a
//   hex value of NUM_DIGITS nibbles with per-digit decimal points, optional

---
 rtl/fys_mux_driver_if.sv | 25 ++
 rtl/fys_mux_driver.sv | 180 ++++++++++++++++++
 tb/tb_fys_mux_driver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fys_mux_driver_if.sv
// Value handshake bundle for the multiplexed 7-segment driver: the producer
// offers a full display value with per-digit decimal points, and the driver
// reports whether its single pending slot can take one.
interface fys_mux_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    value_valid;
  logic                    value_ready;
  logic [4*NUM_DIGITS-1:0] value_data;
  logic [NUM_DIGITS-1:0]   dp_data;

  modport master (
    output value_valid,
    output value_data,
    output dp_data,
    input  value_ready
  );

  modport slave (
    input  value_valid,
    input  value_data,
    input  dp_data,
    output value_ready
  );
endinterface

// File: rtl/fys_mux_driver.sv
// Time-multiplexed hex display driver. Each digit owns a slot of REFRESH_DIV
// cycles, the first GUARD_CYCLES of which keep every anode off so the previous
// digit's segments cannot ghost onto the next one. New values wait in a
// one-entry pending buffer and are only copied into the display registers at
// a frame boundary, so a frame is always drawn from a single value.
module fys_mux_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  fys_mux_driver_if.slave       valueIf,
  input  logic                  blank_lz,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic                  frame_tick
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [SW-1:0]         SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]         DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? '1 : '0;

  // Hex nibble to active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hexDecode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  logic [SW-1:0]         slotCnt_q, slotCnt_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [VW-1:0]         dispVal_q, dispVal_d;
  logic [NUM_DIGITS-1:0] dispDp_q, dispDp_d;
  logic [VW-1:0]         pendVal_q, pendVal_d;
  logic [NUM_DIGITS-1:0] pendDp_q, pendDp_d;
  logic                  pendFull_q, pendFull_d;

  logic [6:0]            segments_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] anodes_q;
  logic                  frameTick_q;

  logic                  slotWrap;
  logic                  frameEnd;
  logic                  accept;

  logic [3:0]            curNib;
  logic                  curDp;
  logic                  curLeadZero;
  logic                  zeroAbove;
  logic                  inGuard;
  logic [6:0]            segPat;
  logic [NUM_DIGITS-1:0] anOn;

  assign valueIf.value_ready = !pendFull_q;
  assign accept              = valueIf.value_valid && !pendFull_q;

  // Slot counter and digit index advance; a frame ends when the last digit's slot wraps
  always_comb begin
    slotCnt_d = slotCnt_q + 1'b1;
    digit_d   = digit_q;
    slotWrap  = (slotCnt_q == SLOT_LAST);
    frameEnd  = slotWrap && (digit_q == DIGIT_LAST);
    if (slotWrap) begin
      slotCnt_d = '0;
      digit_d   = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
    end
  end

  // Boundary copy uses the pending contents from before this edge; a new value can only land when pending was empty
  always_comb begin
    dispVal_d  = dispVal_q;
    dispDp_d   = dispDp_q;
    pendVal_d  = pendVal_q;
    pendDp_d   = pendDp_q;
    pendFull_d = pendFull_q;
    if (frameEnd && pendFull_q) begin
      dispVal_d  = pendVal_q;
      dispDp_d   = pendDp_q;
      pendFull_d = 1'b0;
    end
    if (accept) begin
      pendVal_d  = valueIf.value_data;
      pendDp_d   = valueIf.dp_data;
      pendFull_d = 1'b1;
    end
  end

  // Select the active digit's nibble and dp, tracking whether it and every more-significant nibble are zero
  always_comb begin
    curNib      = 4'h0;
    curDp       = 1'b0;
    curLeadZero = 1'b0;
    zeroAbove   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeroAbove = zeroAbove && (dispVal_q[4*i +: 4] == 4'h0);
      if (digit_q == DW'(i)) begin
        curNib      = dispVal_q[4*i +: 4];
        curDp       = dispDp_q[i];
        curLeadZero = zeroAbove && (i != 0);
      end
    end
  end

  // Build the active-high pin patterns for the current slot before polarity is applied
  always_comb begin
    inGuard = (int'(slotCnt_q) < GUARD_CYCLES);
    segPat  = (blank_lz && curLeadZero) ? 7'h00 : hexDecode(curNib);
    anOn    = inGuard ? '0 : (NUM_DIGITS'(1) << digit_q);
  end

  // Counters, pending buffer and display registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slotCnt_q  <= '0;
      digit_q    <= '0;
      dispVal_q  <= '0;
      dispDp_q   <= '0;
      pendVal_q  <= '0;
      pendDp_q   <= '0;
      pendFull_q <= 1'b0;
    end else begin
      slotCnt_q  <= slotCnt_d;
      digit_q    <= digit_d;
      dispVal_q  <= dispVal_d;
      dispDp_q   <= dispDp_d;
      pendVal_q  <= pendVal_d;
      pendDp_q   <= pendDp_d;
      pendFull_q <= pendFull_d;
    end
  end

  // Registered pins so the board sees glitch-free levels, reset to their inactive polarity
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      segments_q  <= SEG_OFF;
      dp_q        <= DP_OFF;
      anodes_q    <= AN_OFF;
      frameTick_q <= 1'b0;
    end else begin
      segments_q  <= SEG_ACTIVE_LOW ? ~segPat : segPat;
      dp_q        <= SEG_ACTIVE_LOW ? ~curDp : curDp;
      anodes_q    <= AN_ACTIVE_LOW ? ~anOn : anOn;
      frameTick_q <= frameEnd;
    end
  end

  assign segments   = segments_q;
  assign dp         = dp_q;
  assign anodes     = anodes_q;
  assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_fys_mux_driver.sv
// Bench for the multiplexed display driver: a 4-digit instance and a 1-digit
// inverted-segment instance run side by side from the same clock and reset.
// A reference model derives every pin level from elapsed cycles since reset
// and the value each frame is showing; a monitor compares each cycle.
module tb_fys_mux_driver;

  localparam int R = 8;
  localparam int G = 2;

  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
    logic       rdy;
  } obsT;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic blz0 = 1'b0;
  logic blz1 = 1'b0;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0;
  logic [0:0] an1;
  logic       tick0, tick1;

  int tests = 0;
  int fails = 0;

  obsT q0[$];
  obsT q1[$];

  // Model state: cycles since reset release, and what each instance shows / holds
  int          k;
  logic [15:0] disp0, pend0, disp1, pend1;
  logic [3:0]  dpd0, dpp0, dpd1, dpp1;
  bit          full0, full1;
  bit          acc0, acc1;
  obsT         e0, e1;

  always #5 clk = ~clk;

  fys_mux_driver_if #(.NUM_DIGITS(4)) if0 ();
  fys_mux_driver_if #(.NUM_DIGITS(1)) if1 ();

  fys_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(R), .GUARD_CYCLES(G),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut0 (
    .clk(clk), .rstn(rstn), .valueIf(if0), .blank_lz(blz0),
    .segments(seg0), .dp(dp0), .anodes(an0), .frame_tick(tick0)
  );

  fys_mux_driver #(
    .NUM_DIGITS(1), .REFRESH_DIV(R), .GUARD_CYCLES(G),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk(clk), .rstn(rstn), .valueIf(if1), .blank_lz(blz1),
    .segments(seg1), .dp(dp1), .anodes(an1), .frame_tick(tick1)
  );

  // Expected pins after clock edge number kk, given the value on display before that edge
  function automatic obsT expectOut(int n, int kk, logic [15:0] v, logic [3:0] dpv,
                                    logic blz, bit segLow, bit rdy);
    obsT         e;
    int          slot;
    int          dig;
    logic [15:0] upper;
    logic [3:0]  anHigh;
    slot   = kk % R;
    dig    = (kk / R) % n;
    upper  = v >> (4 * dig);
    e.seg  = (blz && dig > 0 && upper == 16'h0) ? 7'h00 : DEC[upper[3:0]];
    e.dp   = dpv[dig];
    if (segLow) begin
      e.seg = ~e.seg;
      e.dp  = ~e.dp;
    end
    anHigh = (slot < G) ? 4'b0000 : 4'(1 << dig);
    e.an   = ~anHigh & 4'((1 << n) - 1);
    e.tick = ((kk % (n * R)) == (n * R - 1));
    e.rdy  = rdy;
    return e;
  endfunction

  task automatic checkOutput(string name, obsT act, obsT exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s k=%0d: got seg=%h dp=%b an=%b tick=%b rdy=%b, expected seg=%h dp=%b an=%b tick=%b rdy=%b",
               name, k, act.seg, act.dp, act.an, act.tick, act.rdy,
               exp.seg, exp.dp, exp.an, exp.tick, exp.rdy);
    end
  endtask

  // Reference model: predict the pins each edge produces, then apply the frame-boundary copy and any accept
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k     = 0;
      disp0 = '0; pend0 = '0; dpd0 = '0; dpp0 = '0; full0 = 1'b0;
      disp1 = '0; pend1 = '0; dpd1 = '0; dpp1 = '0; full1 = 1'b0;
    end else begin
      e0   = expectOut(4, k, disp0, dpd0, blz0, 1'b0, 1'b0);
      e1   = expectOut(1, k, disp1, dpd1, blz1, 1'b1, 1'b0);
      acc0 = if0.value_valid && !full0;
      acc1 = if1.value_valid && !full1;
      if ((k % (4 * R)) == 4 * R - 1 && full0) begin
        disp0 = pend0; dpd0 = dpp0; full0 = 1'b0;
      end
      if ((k % R) == R - 1 && full1) begin
        disp1 = pend1; dpd1 = dpp1; full1 = 1'b0;
      end
      if (acc0) begin
        pend0 = if0.value_data; dpp0 = if0.dp_data; full0 = 1'b1;
      end
      if (acc1) begin
        pend1 = {12'h000, if1.value_data}; dpp1 = {3'b000, if1.dp_data}; full1 = 1'b1;
      end
      e0.rdy = !full0;
      e1.rdy = !full1;
      q0.push_back(e0);
      q1.push_back(e1);
      k++;
    end
  end

  // Monitor: every cycle the DUTs present their pins; pop the prediction and compare
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() == 0 || q1.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL scoreboard k=%0d: got q0=%0d q1=%0d entries, expected at least 1 each",
                 k, q0.size(), q1.size());
      end else begin
        checkOutput("pins4", {seg0, dp0, an0, tick0, if0.value_ready}, q0.pop_front());
        checkOutput("pins1", {seg1, dp1, 3'b000, an1, tick1, if1.value_ready}, q1.pop_front());
      end
    end
  end

  // Both instances must sit at their inactive levels with ready high while reset is held
  task automatic checkResetPins(string tag);
    checkOutput({tag, "4"}, {seg0, dp0, an0, tick0, if0.value_ready},
                {7'h00, 1'b0, 4'b1111, 1'b0, 1'b1});
    checkOutput({tag, "1"}, {seg1, dp1, 3'b000, an1, tick1, if1.value_ready},
                {7'h7F, 1'b1, 4'b0001, 1'b0, 1'b1});
  endtask

  // Random traffic; lzBias shortens values so leading-zero blanking gets exercised
  task automatic applyStimulus(int cycles, int validPct, bit lzBias);
    logic [15:0] v;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      v = 16'($urandom);
      if (lzBias) v = v >> (4 * $urandom_range(4, 0));
      if0.value_valid = ($urandom_range(99, 0) < validPct);
      if0.value_data  = v;
      if0.dp_data     = 4'($urandom);
      if1.value_valid = ($urandom_range(99, 0) < validPct);
      if1.value_data  = 4'($urandom);
      if1.dp_data     = 1'($urandom);
      if ($urandom_range(39, 0) == 0) blz0 = ~blz0;
      if ($urandom_range(39, 0) == 0) blz1 = ~blz1;
    end
  endtask

  // Offer one value to the 4-digit instance for a single cycle
  task automatic sendValue(logic [15:0] v, logic [3:0] dpv);
    @(negedge clk);
    if0.value_valid = 1'b1;
    if0.value_data  = v;
    if0.dp_data     = dpv;
    @(negedge clk);
    if0.value_valid = 1'b0;
  endtask

  initial begin
    if0.value_valid = 1'b0; if0.value_data = '0; if0.dp_data = '0;
    if1.value_valid = 1'b0; if1.value_data = '0; if1.dp_data = '0;
    repeat (3) @(negedge clk);
    checkResetPins("reset_hold");
    #2 rstn = 1'b1;

    applyStimulus(80, 0, 1'b0);
    sendValue(16'h12AF, 4'b0100);
    applyStimulus(70, 0, 1'b0);
    blz0 = 1'b1;
    sendValue(16'h0007, 4'b0000);
    applyStimulus(70, 0, 1'b0);
    sendValue(16'h0000, 4'b0001);
    applyStimulus(70, 0, 1'b0);

    applyStimulus(300, 10, 1'b1);
    applyStimulus(200, 100, 1'b1);

    @(posedge clk);
    #2 rstn = 1'b0;
    #1 checkResetPins("reset_async");
    @(negedge clk);
    #2 rstn = 1'b1;

    applyStimulus(400, 25, 1'b1);
    applyStimulus(100, 0, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
